// File: rtl/spi_controller_pkg.sv
// Shared definitions for the SPI controller: register map, CTRL/STATUS
// bit positions, engine configuration word and FSM states.
package spi_controller_pkg;

   localparam logic [3:0] ADDR_CTRL   = 4'h0;
   localparam logic [3:0] ADDR_STATUS = 4'h4;
   localparam logic [3:0] ADDR_TXDATA = 4'h8;
   localparam logic [3:0] ADDR_RXDATA = 4'hC;

   // CTRL layout; bits [8:0] map one-to-one onto spi_config_t
   localparam int CTRL_W         = 13;
   localparam int CTRL_CFG_MSB   = 8;
   localparam int CTRL_CS_AUTO   = 9;
   localparam int CTRL_CS_LEVEL  = 10;
   localparam int CTRL_RX_IRQ_EN = 11;
   localparam int CTRL_ENABLE    = 12;

   // STATUS layout
   localparam int STAT_W        = 7;
   localparam int STAT_TX_EMPTY = 0;
   localparam int STAT_TX_FULL  = 1;
   localparam int STAT_RX_EMPTY = 2;
   localparam int STAT_RX_FULL  = 3;
   localparam int STAT_TX_OVF   = 4;
   localparam int STAT_RX_OVF   = 5;
   localparam int STAT_ACTIVE   = 6;

   typedef struct packed {
      logic [3:0] prescaler;
      logic       bit_order;
      logic [1:0] frame_size;
      logic [1:0] mode;
   } spi_config_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_WAIT_HI,
      ST_WAIT_LO,
      ST_CAPTURE
   } state_t;

endpackage

// File: rtl/spi_controller_if.sv
// CPU-side register bus of the SPI controller.
interface spi_controller_if;
   logic [3:0]  bus_addr;
   logic        bus_wr;
   logic        bus_rd;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        irq;

   modport master (
      output bus_addr, bus_wr, bus_rd, bus_wdata,
      input  bus_rdata, irq
   );

   modport slave (
      input  bus_addr, bus_wr, bus_rd, bus_wdata,
      output bus_rdata, irq
   );
endinterface

// File: rtl/spi_fifo.sv
// Synchronous FIFO with wrap-bit pointers. Pushes while full and pops
// while empty are ignored; the caller decides whether that is an error.
module spi_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr[AW-1:0]];

   // pointer update; simultaneous push and pop leave the count unchanged
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // storage write, no reset needed since reads are qualified by empty
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end
endmodule

// File: rtl/spi_controller.sv
// Memory-mapped SPI controller: CTRL/STATUS registers, TX/RX FIFOs and
// the sequencer that launches one engine transfer per TX word.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | no transfer; launch when enabled and TX FIFO has data
// ST_SETUP   | CS setup cycle; tx_start pulses on leaving
// ST_WAIT_HI | waiting for the engine to raise busy
// ST_WAIT_LO | engine shifting; waiting for busy to drop
// ST_CAPTURE | push rx_data; chain next word or return to idle
module spi_controller
   import spi_controller_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   spi_controller_if.slave bus,
   output logic            cs_n,
   output logic            tx_start,
   output logic [31:0]     tx_data,
   input  logic [31:0]     rx_data,
   input  logic            busy,
   output spi_config_t     spi_config
);
   state_t              state;
   logic [CTRL_W-1:0]   ctrl;
   logic                tx_ovf;
   logic                rx_ovf;
   logic                cs_act;

   logic                tx_push;
   logic                tx_pop;
   logic                tx_empty;
   logic                tx_full;
   logic [31:0]         tx_head;
   logic                rx_push;
   logic                rx_pop;
   logic                rx_empty;
   logic                rx_full;
   logic [31:0]         rx_head;

   logic                wr_ctrl;
   logic                wr_status;
   logic                launch;
   logic [STAT_W-1:0]   status;
   logic [31:0]         rd_mux;
   logic                unused_wdata;

   assign wr_ctrl   = bus.bus_wr && (bus.bus_addr == ADDR_CTRL);
   assign wr_status = bus.bus_wr && (bus.bus_addr == ADDR_STATUS);
   assign tx_push   = bus.bus_wr && (bus.bus_addr == ADDR_TXDATA);
   assign rx_pop    = bus.bus_rd && (bus.bus_addr == ADDR_RXDATA);

   // a launch pops the TX head and latches config, from IDLE or chained from CAPTURE
   assign launch  = ((state == ST_IDLE) || (state == ST_CAPTURE))
                    && ctrl[CTRL_ENABLE] && !tx_empty;
   assign tx_pop  = launch;
   assign rx_push = (state == ST_CAPTURE);

   assign cs_n    = ctrl[CTRL_CS_AUTO] ? ~cs_act : ~ctrl[CTRL_CS_LEVEL];
   assign bus.irq = ctrl[CTRL_RX_IRQ_EN] && !rx_empty;

   assign unused_wdata = ^bus.bus_wdata[31:CTRL_W];

   spi_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (tx_push),
      .push_data (bus.bus_wdata),
      .pop       (tx_pop),
      .head      (tx_head),
      .empty     (tx_empty),
      .full      (tx_full)
   );

   spi_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rx_push),
      .push_data (rx_data),
      .pop       (rx_pop),
      .head      (rx_head),
      .empty     (rx_empty),
      .full      (rx_full)
   );

   // status word as seen by a STATUS read
   always_comb begin
      status                = '0;
      status[STAT_TX_EMPTY] = tx_empty;
      status[STAT_TX_FULL]  = tx_full;
      status[STAT_RX_EMPTY] = rx_empty;
      status[STAT_RX_FULL]  = rx_full;
      status[STAT_TX_OVF]   = tx_ovf;
      status[STAT_RX_OVF]   = rx_ovf;
      status[STAT_ACTIVE]   = (state != ST_IDLE);
   end

   // read data select; empty RX reads return zero
   always_comb begin
      rd_mux = '0;
      case (bus.bus_addr)
         ADDR_CTRL:   rd_mux = {{(32-CTRL_W){1'b0}}, ctrl};
         ADDR_STATUS: rd_mux = {{(32-STAT_W){1'b0}}, status};
         ADDR_RXDATA: rd_mux = rx_empty ? '0 : rx_head;
         default:     rd_mux = '0;
      endcase
   end

   // register file: CTRL, sticky overflow flags (set wins over W1C), read data
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctrl          <= '0;
         tx_ovf        <= 1'b0;
         rx_ovf        <= 1'b0;
         bus.bus_rdata <= '0;
      end else begin
         if (wr_ctrl) ctrl <= bus.bus_wdata[CTRL_W-1:0];

         if (tx_push && tx_full)
            tx_ovf <= 1'b1;
         else if (wr_status && bus.bus_wdata[STAT_TX_OVF])
            tx_ovf <= 1'b0;

         if (rx_push && rx_full)
            rx_ovf <= 1'b1;
         else if (wr_status && bus.bus_wdata[STAT_RX_OVF])
            rx_ovf <= 1'b0;

         bus.bus_rdata <= bus.bus_rd ? rd_mux : '0;
      end
   end

   // transfer sequencer with registered engine-side outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         tx_start   <= 1'b0;
         tx_data    <= '0;
         spi_config <= '0;
         cs_act     <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         if (launch) begin
            spi_config <= spi_config_t'(ctrl[CTRL_CFG_MSB:0]);
            tx_data    <= tx_head;
            cs_act     <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (launch) state <= ST_SETUP;
            end
            ST_SETUP: begin
               tx_start <= 1'b1;
               state    <= ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
               if (busy) state <= ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
               if (!busy) state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               if (launch) begin
                  state <= ST_SETUP;
               end else begin
                  state  <= ST_IDLE;
                  cs_act <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller with a behavioural SPI engine in
// loopback (received word = transmitted word trimmed to the frame size).
module tb_spi_controller;
   import spi_controller_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cs_n;
   logic        tx_start;
   logic [31:0] tx_data;
   logic [31:0] rx_data;
   logic        busy;
   spi_config_t spi_config;

   spi_controller_if bus_if ();

   spi_controller #(.FIFO_DEPTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus_if),
      .cs_n       (cs_n),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .rx_data    (rx_data),
      .busy       (busy),
      .spi_config (spi_config)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // engine model: busy for 5 cycles starting the cycle after tx_start
   function automatic logic [31:0] frame_mask(input logic [31:0] w, input logic [1:0] fs);
      case (fs)
         2'd0:    return {24'b0, w[7:0]};
         2'd1:    return {16'b0, w[15:0]};
         2'd2:    return {8'b0, w[23:0]};
         default: return w;
      endcase
   endfunction

   logic [2:0]  eng_cnt;
   logic [31:0] eng_word;
   always @(posedge clk) begin
      if (!rst_n) begin
         busy     <= 1'b0;
         eng_cnt  <= '0;
         eng_word <= '0;
         rx_data  <= '0;
      end else if (busy) begin
         if (eng_cnt == 0) begin
            busy    <= 1'b0;
            rx_data <= eng_word;
         end else begin
            eng_cnt <= eng_cnt - 1'b1;
         end
      end else if (tx_start) begin
         busy     <= 1'b1;
         eng_cnt  <= 3'd4;
         eng_word <= frame_mask(tx_data, spi_config.frame_size);
      end
   end

   // monitor sampled on the falling edge
   int         n_start = 0;
   int         start_cyc [64];
   int         gap_log [64];
   logic [8:0] cfg_log [64];
   int         fall_cyc = 0;
   int         irq_rise_cyc = 0;
   int         cs_rise = 0;
   int         cs_viol = 0;
   int         dbl_pulse = 0;
   logic       ts_q = 1'b0, busy_q = 1'b0, irq_q = 1'b0, cs_q = 1'b1;

   always @(negedge clk) begin
      if (tx_start && !ts_q) begin
         if (n_start < 64) begin
            start_cyc[n_start] = cyc;
            gap_log[n_start]   = cyc - fall_cyc;
            cfg_log[n_start]   = spi_config;
         end
         n_start = n_start + 1;
      end
      if (tx_start && ts_q) dbl_pulse = dbl_pulse + 1;
      if (busy_q && !busy) fall_cyc = cyc;
      if (bus_if.irq && !irq_q) irq_rise_cyc = cyc;
      if (busy && cs_n) cs_viol = cs_viol + 1;
      if (cs_n && !cs_q) cs_rise = cs_rise + 1;
      ts_q   = tx_start;
      busy_q = busy;
      irq_q  = bus_if.irq;
      cs_q   = cs_n;
   end

   int n_pass = 0;
   int n_chk  = 0;
   int last_op_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (act === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic bus_op(input logic wr, input logic rd, input logic [3:0] addr,
                         input logic [31:0] wd, output logic [31:0] rv);
      @(negedge clk);
      bus_if.bus_wr    = wr;
      bus_if.bus_rd    = rd;
      bus_if.bus_addr  = addr;
      bus_if.bus_wdata = wd;
      @(negedge clk);
      rv          = bus_if.bus_rdata;
      last_op_cyc = cyc;
      bus_if.bus_wr = 1'b0;
      bus_if.bus_rd = 1'b0;
   endtask

   task automatic bus_wr(input logic [3:0] addr, input logic [31:0] wd);
      logic [31:0] dummy;
      bus_op(1'b1, 1'b0, addr, wd, dummy);
   endtask

   task automatic bus_rd(input logic [3:0] addr, output logic [31:0] rv);
      bus_op(1'b0, 1'b1, addr, 32'h0, rv);
   endtask

   task automatic wait_idle(input string name);
      logic [31:0] s;
      int k;
      k = 0;
      s = '0;
      do begin
         bus_rd(ADDR_STATUS, s);
         k++;
      end while ((s[6] || !s[0]) && k < 400);
      check(name, {31'b0, !s[6] && s[0]}, 32'd1);
   endtask

   typedef struct {
      logic        wr;
      logic        rd;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_cs_n;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic wr, input logic rd, input logic [3:0] addr,
                               input logic [31:0] wd, input logic [31:0] er,
                               input logic ecs, input logic eirq);
      vec_t v;
      v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wd;
      v.exp_rdata = er; v.exp_cs_n = ecs; v.exp_irq = eirq;
      vecs.push_back(v);
   endfunction

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] rv;
      int s0, cr0, wr_cyc, k;

      bus_if.bus_wr    = 1'b0;
      bus_if.bus_rd    = 1'b0;
      bus_if.bus_addr  = 4'h0;
      bus_if.bus_wdata = 32'h0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // reset state
      check("rst cs_n", {31'b0, cs_n}, 32'd1);
      check("rst tx_start", {31'b0, tx_start}, 32'd0);
      check("rst tx_data", tx_data, 32'h0);
      check("rst spi_config", {23'b0, spi_config}, 32'h0);
      check("rst irq", {31'b0, bus_if.irq}, 32'd0);
      check("rst rdata", bus_if.bus_rdata, 32'h0);
      bus_rd(ADDR_STATUS, rv);
      check("rst status", rv, 32'h05);

      // register and FIFO-flag vectors with the controller disabled
      add(1, 0, ADDR_CTRL,   32'h0000_0400, 0,       0, 0);
      add(0, 1, ADDR_CTRL,   0,             32'h400, 0, 0);
      add(1, 0, ADDR_CTRL,   32'hFFFF_EFFF, 0,       1, 0);
      add(0, 1, ADDR_CTRL,   0,             32'hFFF, 1, 0);
      add(1, 0, ADDR_CTRL,   32'h0,         0,       1, 0);
      add(0, 1, ADDR_TXDATA, 0,             0,       1, 0);
      add(0, 1, ADDR_RXDATA, 0,             0,       1, 0);
      add(1, 0, ADDR_RXDATA, 32'h1234,      0,       1, 0);
      add(0, 1, ADDR_STATUS, 0,             32'h05,  1, 0);
      for (int i = 0; i < 8; i++)
         add(1, 0, ADDR_TXDATA, 32'h100 + 32'(i), 0, 1, 0);
      add(0, 1, ADDR_STATUS, 0,             32'h06,  1, 0);
      add(1, 0, ADDR_TXDATA, 32'h108,       0,       1, 0);
      add(0, 1, ADDR_STATUS, 0,             32'h16,  1, 0);
      add(1, 0, ADDR_STATUS, 32'h10,        0,       1, 0);
      add(0, 1, ADDR_STATUS, 0,             32'h06,  1, 0);

      foreach (vecs[i]) begin
         bus_op(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, rv);
         if (vecs[i].rd) check($sformatf("vec%0d rdata", i), rv, vecs[i].exp_rdata);
         check($sformatf("vec%0d cs_n", i), {31'b0, cs_n}, {31'b0, vecs[i].exp_cs_n});
         check($sformatf("vec%0d irq", i), {31'b0, bus_if.irq}, {31'b0, vecs[i].exp_irq});
      end

      // burst of the 8 queued words, 32-bit frames: CS held, 2-cycle gaps
      s0  = n_start;
      cr0 = cs_rise;
      bus_wr(ADDR_CTRL, 32'h120C);
      wait_idle("burst idle");
      bus_rd(ADDR_STATUS, rv);
      check("burst status", rv, 32'h09);
      check("burst starts", 32'(n_start - s0), 32'd8);
      check("burst cs rises", 32'(cs_rise - cr0), 32'd1);
      check("burst cfg", {23'b0, cfg_log[s0]}, 32'h00C);
      for (int i = 1; i < 8; i++)
         check($sformatf("burst gap%0d", i), 32'(gap_log[s0 + i]), 32'd3);

      // ninth word with RX full is dropped and flags rx_ovf
      bus_wr(ADDR_TXDATA, 32'hDEAD_BEEF);
      wait_idle("ovf idle");
      bus_rd(ADDR_STATUS, rv);
      check("rx_ovf status", rv, 32'h29);
      bus_wr(ADDR_STATUS, 32'h20);
      bus_rd(ADDR_STATUS, rv);
      check("rx_ovf w1c", rv, 32'h09);
      bus_wr(ADDR_CTRL, 32'h1A0C);
      check("irq en full", {31'b0, bus_if.irq}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         bus_rd(ADDR_RXDATA, rv);
         check($sformatf("rx word%0d", i), rv, 32'h100 + 32'(i));
      end
      check("irq drained", {31'b0, bus_if.irq}, 32'd0);
      bus_rd(ADDR_RXDATA, rv);
      check("rx empty read", rv, 32'h0);

      // single 8-bit word: latency, capture timing, irq gating
      bus_wr(ADDR_CTRL, 32'h1A00);
      s0 = n_start;
      bus_wr(ADDR_TXDATA, 32'hFFFF_FFA5);
      wr_cyc = last_op_cyc;
      wait_idle("single idle");
      check("single starts", 32'(n_start - s0), 32'd1);
      check("single latency", 32'(start_cyc[s0] - wr_cyc), 32'd2);
      check("single cfg", {23'b0, cfg_log[s0]}, 32'h000);
      check("capture latency", 32'(irq_rise_cyc - fall_cyc), 32'd2);
      check("single irq", {31'b0, bus_if.irq}, 32'd1);
      bus_wr(ADDR_CTRL, 32'h1200);
      check("irq disabled", {31'b0, bus_if.irq}, 32'd0);
      bus_rd(ADDR_RXDATA, rv);
      check("single rx", rv, 32'hA5);

      // CTRL change mid-transfer only affects the next launch
      bus_wr(ADDR_CTRL, 32'h120C);
      s0 = n_start;
      bus_wr(ADDR_TXDATA, 32'h1111_1111);
      bus_wr(ADDR_TXDATA, 32'h2222_2222);
      k = 0;
      while (n_start <= s0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("mode first start", {31'b0, n_start > s0}, 32'd1);
      bus_wr(ADDR_CTRL, 32'h120F);
      check("mode held", {23'b0, spi_config}, 32'h00C);
      wait_idle("mode idle");
      check("mode cfg0", {23'b0, cfg_log[s0]}, 32'h00C);
      check("mode cfg1", {23'b0, cfg_log[s0 + 1]}, 32'h00F);
      check("mode gap", 32'(gap_log[s0 + 1]), 32'd3);
      bus_rd(ADDR_RXDATA, rv);
      check("mode rx0", rv, 32'h1111_1111);
      bus_rd(ADDR_RXDATA, rv);
      check("mode rx1", rv, 32'h2222_2222);

      // reset in the middle of a transfer
      bus_wr(ADDR_CTRL, 32'h1200);
      bus_wr(ADDR_TXDATA, 32'h5A);
      k = 0;
      while (!busy && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("midrst busy seen", {31'b0, busy}, 32'd1);
      check("midrst cs low", {31'b0, cs_n}, 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst cs_n", {31'b0, cs_n}, 32'd1);
      check("midrst tx_start", {31'b0, tx_start}, 32'd0);
      check("midrst busy", {31'b0, busy}, 32'd0);
      check("midrst tx_data", tx_data, 32'h0);
      check("midrst cfg", {23'b0, spi_config}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bus_rd(ADDR_STATUS, rv);
      check("midrst status", rv, 32'h05);
      bus_rd(ADDR_CTRL, rv);
      check("midrst ctrl", rv, 32'h0);

      check("cs high while busy", 32'(cs_viol), 32'd0);
      check("tx_start width", 32'(dbl_pulse), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
